// File: rtl/gayle_pccard_cycle_if.sv
// CPU-side request/acknowledge bus of the Gayle PC Card cycle sequencer.
interface gayle_pccard_cycle_if;
    logic        cpu_sel;
    logic [23:1] cpu_addr;
    logic        cpu_rd;
    logic        cpu_hwr;
    logic        cpu_lwr;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_ack;

    modport master (
        output cpu_sel, cpu_addr, cpu_rd, cpu_hwr, cpu_lwr, cpu_data_in,
        input  cpu_data_out, cpu_ack
    );

    modport slave (
        input  cpu_sel, cpu_addr, cpu_rd, cpu_hwr, cpu_lwr, cpu_data_in,
        output cpu_data_out, cpu_ack
    );
endinterface

// File: rtl/gayle_pccard_cycle.sv
// Gayle PC Card bus-cycle sequencer: window decode, timed card strobes,
// byte-lane steering, read latch and synchronised card interrupt.
module gayle_pccard_cycle #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    gayle_pccard_cycle_if.slave        cpu,
    input  logic                       card_enable,
    output logic [25:0]                addr,
    output logic [15:0]                data_to_card,
    input  logic [15:0]                data_from_card,
    output logic                       cc_reg,
    output logic                       cc_oe,
    output logic                       cc_we,
    output logic                       cc_iord,
    output logic                       cc_iowr,
    output logic                       cc_ce1,
    output logic                       cc_ce2,
    input  logic                       cc_ireq,
    input  logic                       irq_enable,
    input  logic                       irq_clear,
    output logic                       irq
);

    localparam int unsigned MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAXC   = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
    localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_STROBE = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_ACK,
        S_WAITREL
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [25:0]   addr_q, addr_d;
    logic          reg_q, reg_d;
    logic          io_q, io_d;
    logic          rd_q, rd_d;
    logic          ce2_q, ce2_d;
    logic          hi_q, hi_d;
    logic          lo_q, lo_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          s1_q, s2_q, s3_q;
    logic          pend_q, pend_d;

    logic          win_com, win_att, win_io, in_win;
    logic          hi_only, lo_only;
    logic [23:1]   woff;
    logic [15:0]   rd_steer;
    logic          active, strobe;

    // Windows are decoded on the word address; A0 is implied zero.
    always_comb begin
        win_com = (cpu.cpu_addr >= 23'h300000) && (cpu.cpu_addr <= 23'h4FFFFF);
        win_att = (cpu.cpu_addr[23:17] == 7'h50);
        win_io  = (cpu.cpu_addr[23:17] == 7'h51);
        in_win  = win_com | win_att | win_io;
        hi_only = cpu.cpu_hwr & ~cpu.cpu_lwr;
        lo_only = cpu.cpu_lwr & ~cpu.cpu_hwr;
        woff    = win_com ? (cpu.cpu_addr - 23'h300000)
                          : {7'd0, cpu.cpu_addr[16:1]};
    end

    // Single-byte reads return $FF in the lane the card did not drive.
    always_comb begin
        unique case (1'b1)
            hi_q:    rd_steer = {data_from_card[7:0], 8'hFF};
            lo_q:    rd_steer = {8'hFF, data_from_card[7:0]};
            default: rd_steer = data_from_card;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        io_d    = io_q;
        rd_d    = rd_q;
        ce2_d   = ce2_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu.cpu_sel && in_win) begin
                    addr_d  = {2'b00, woff, lo_only};
                    reg_d   = ~win_com;
                    io_d    = win_io;
                    rd_d    = cpu.cpu_rd;
                    ce2_d   = ~(hi_only | lo_only);
                    hi_d    = hi_only;
                    lo_d    = lo_only;
                    wdata_d = hi_only ? {8'h00, cpu.cpu_data_in[15:8]}
                                      : cpu.cpu_data_in;
                    if (card_enable) begin
                        state_d = S_SETUP;
                        cnt_d   = LD_SETUP;
                    end else begin
                        state_d = S_ACK;
                        if (cpu.cpu_rd) rdata_d = 16'hFFFF;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = LD_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                    if (rd_q) rdata_d = rd_steer;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = S_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACK:     state_d = S_WAITREL;
            S_WAITREL: if (!cpu.cpu_sel) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            reg_q   <= 1'b0;
            io_q    <= 1'b0;
            rd_q    <= 1'b0;
            ce2_q   <= 1'b0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            reg_q   <= reg_d;
            io_q    <= io_d;
            rd_q    <= rd_d;
            ce2_q   <= ce2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from state so reset drops them at once.
    always_comb begin
        active       = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                       (state_q == S_HOLD);
        strobe       = (state_q == S_STROBE);
        addr         = active ? addr_q : 26'd0;
        cc_reg       = active & reg_q;
        cc_ce1       = active;
        cc_ce2       = active & ce2_q;
        cc_oe        = strobe & rd_q & ~io_q;
        cc_we        = strobe & ~rd_q & ~io_q;
        cc_iord      = strobe & rd_q & io_q;
        cc_iowr      = strobe & ~rd_q & io_q;
        data_to_card = (active & ~rd_q) ? wdata_q : 16'd0;
        cpu.cpu_ack      = (state_q == S_ACK);
        cpu.cpu_data_out = rdata_q;
    end

    always_comb begin
        pend_d = pend_q;
        if (irq_clear)       pend_d = 1'b0;
        if (s2_q && !s3_q)   pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s1_q   <= cc_ireq;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            pend_q <= pend_d;
        end
    end

    assign irq = pend_q & irq_enable;

endmodule

// File: tb/tb_gayle_pccard_cycle.sv
// Directed, table-driven bench for the Gayle PC Card cycle sequencer.
module tb_gayle_pccard_cycle;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        card_enable;
    logic [25:0] addr;
    logic [15:0] data_to_card;
    logic [15:0] data_from_card;
    logic        cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2;
    logic        cc_ireq, irq_enable, irq_clear, irq;

    int n_vec = 0;
    int n_mis = 0;

    gayle_pccard_cycle_if bus();

    gayle_pccard_cycle dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu            (bus),
        .card_enable    (card_enable),
        .addr           (addr),
        .data_to_card   (data_to_card),
        .data_from_card (data_from_card),
        .cc_reg         (cc_reg),
        .cc_oe          (cc_oe),
        .cc_we          (cc_we),
        .cc_iord        (cc_iord),
        .cc_iowr        (cc_iowr),
        .cc_ce1         (cc_ce1),
        .cc_ce2         (cc_ce2),
        .cc_ireq        (cc_ireq),
        .irq_enable     (irq_enable),
        .irq_clear      (irq_clear),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [23:1] a;
        logic        hwr;
        logic        lwr;
        logic        en;
        logic [15:0] din;
        logic [15:0] dfc;
        logic        hold_sel;
        logic        x_ack;
        int          x_lat;
        int          x_kind;
        logic [25:0] x_addr;
        logic        x_reg;
        logic        x_ce;
        logic        x_ce2;
        logic [15:0] x_dout;
        logic [15:0] x_dto;
    } vec_t;

    // kind: 0 none, 1 oe, 2 we, 3 iord, 4 iowr
    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        int   lat, n_setup, n_hold, n_ack, n_multi, n_extra, n_tot;
        int   n_st [5];
        bit   seen;
        logic [25:0] sa;
        logic sreg, sce2;
        logic [15:0] sdto;
        logic [3:0] st;
        string t;
        t = $sformatf("v%0d", idx);
        lat = 0; n_setup = 0; n_hold = 0; n_ack = 0; n_multi = 0;
        n_extra = 0; n_tot = 0; seen = 0;
        sa = '0; sreg = 0; sce2 = 0; sdto = '0;
        for (int k = 0; k < 5; k++) n_st[k] = 0;
        @(posedge clk); #1;
        card_enable     = v.en;
        data_from_card  = v.dfc;
        bus.cpu_addr    = v.a;
        bus.cpu_rd      = v.rd;
        bus.cpu_hwr     = v.hwr;
        bus.cpu_lwr     = v.lwr;
        bus.cpu_data_in = v.din;
        bus.cpu_sel     = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            st = {cc_iowr, cc_iord, cc_we, cc_oe};
            if ($countones(st) > 1) n_multi++;
            for (int k = 0; k < 4; k++) if (st[k]) n_st[k+1]++;
            if (cc_ce1) begin
                if (!seen) begin
                    seen = 1; sa = addr; sreg = cc_reg; sce2 = cc_ce2;
                end
                if (st == 4'd0 && n_tot == 0) n_setup++;
                else if (st == 4'd0) n_hold++;
                sdto = data_to_card;
            end
            n_tot = n_st[1] + n_st[2] + n_st[3] + n_st[4];
            if (bus.cpu_ack) begin
                n_ack++;
                if (lat == 0) lat = c;
            end
            if (c == 2 && v.x_ack) begin
                bus.cpu_addr    = ~v.a;
                bus.cpu_data_in = ~v.din;
            end
            if (lat != 0 && c == lat + 1) break;
        end
        if (v.hold_sel) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus.cpu_ack || cc_ce1) n_extra++;
            end
            chk({t, " held_sel_reissue"}, 32'(n_extra), 32'd0);
        end
        chk({t, " ack_seen"}, 32'(n_ack != 0), 32'(v.x_ack));
        if (v.x_ack) begin
            chk({t, " latency"}, 32'(lat), 32'(v.x_lat));
            chk({t, " ack_count"}, 32'(n_ack), 32'd1);
            chk({t, " multi_strobe"}, 32'(n_multi), 32'd0);
            for (int k = 1; k <= 4; k++)
                chk($sformatf("%s strobe%0d_cycles", t, k), 32'(n_st[k]),
                    (k == v.x_kind) ? 32'd4 : 32'd0);
            chk({t, " setup_cycles"}, 32'(n_setup), v.x_ce ? 32'd2 : 32'd0);
            chk({t, " hold_cycles"}, 32'(n_hold), v.x_ce ? 32'd1 : 32'd0);
            chk({t, " dout"}, 32'(bus.cpu_data_out), 32'(v.x_dout));
        end
        chk({t, " ce1_seen"}, 32'(seen), 32'(v.x_ce));
        if (v.x_ce) begin
            chk({t, " addr"}, 32'(sa), 32'(v.x_addr));
            chk({t, " cc_reg"}, 32'(sreg), 32'(v.x_reg));
            chk({t, " cc_ce2"}, 32'(sce2), 32'(v.x_ce2));
            if (!v.rd) chk({t, " data_to_card"}, 32'(sdto), 32'(v.x_dto));
        end
        @(posedge clk); #1;
        bus.cpu_sel = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " strobes"},
            32'({cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2}),
            32'd0);
        chk({nm, " addr"}, 32'(addr), 32'd0);
        chk({nm, " ack"}, 32'(bus.cpu_ack), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         rd a          hw lw en din      dfc      hs ack lat k addr        rg ce c2 dout     dto
        vt[0]  = '{1, 23'h500001, 1, 1, 1, 16'h0000, 16'h1234, 0, 1, 9, 1, 26'h0000002, 1, 1, 1, 16'h1234, 16'h0000};
        vt[1]  = '{0, 23'h510180, 1, 0, 1, 16'hAB00, 16'h0000, 0, 1, 9, 4, 26'h0000300, 1, 1, 0, 16'h1234, 16'h00AB};
        vt[2]  = '{1, 23'h300008, 0, 1, 1, 16'h0000, 16'h9C5A, 1, 1, 9, 1, 26'h0000011, 0, 1, 0, 16'hFF5A, 16'h0000};
        vt[3]  = '{1, 23'h500000, 1, 1, 0, 16'h0000, 16'h4321, 0, 1, 2, 0, 26'h0000000, 0, 0, 0, 16'hFFFF, 16'h0000};
        vt[4]  = '{1, 23'h200000, 1, 1, 1, 16'h0000, 16'h4321, 0, 0, 0, 0, 26'h0000000, 0, 0, 0, 16'hFFFF, 16'h0000};
        vt[5]  = '{0, 23'h4FFFFF, 1, 1, 1, 16'h5A3C, 16'h0000, 0, 1, 9, 2, 26'h03FFFFE, 0, 1, 1, 16'hFFFF, 16'h5A3C};
        vt[6]  = '{1, 23'h50FFFF, 1, 0, 1, 16'h0000, 16'h12C3, 0, 1, 9, 1, 26'h001FFFE, 1, 1, 0, 16'hC3FF, 16'h0000};
        vt[7]  = '{1, 23'h51FFFF, 0, 0, 1, 16'h0000, 16'hBEEF, 0, 1, 9, 3, 26'h001FFFE, 1, 1, 1, 16'hBEEF, 16'h0000};
        vt[8]  = '{1, 23'h520000, 1, 1, 1, 16'h0000, 16'h1111, 0, 0, 0, 0, 26'h0000000, 0, 0, 0, 16'hBEEF, 16'h0000};
        vt[9]  = '{0, 23'h300000, 0, 1, 1, 16'h1177, 16'h0000, 0, 1, 9, 2, 26'h0000001, 0, 1, 0, 16'hBEEF, 16'h1177};
        vt[10] = '{1, 23'h2FFFFF, 1, 1, 1, 16'h0000, 16'h2222, 0, 0, 0, 0, 26'h0000000, 0, 0, 0, 16'hBEEF, 16'h0000};
        vt[11] = '{0, 23'h510000, 1, 1, 0, 16'h7777, 16'h3333, 0, 1, 2, 0, 26'h0000000, 0, 0, 0, 16'hBEEF, 16'h0000};

        reset_n = 1'b0;
        card_enable = 1'b0;
        data_from_card = '0;
        cc_ireq = 1'b0;
        irq_enable = 1'b0;
        irq_clear = 1'b0;
        bus.cpu_sel = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_rd = 1'b0;
        bus.cpu_hwr = 1'b0;
        bus.cpu_lwr = 1'b0;
        bus.cpu_data_in = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_quiet("reset");
        chk("reset dout", 32'(bus.cpu_data_out), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        chk("reset dto", 32'(data_to_card), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) apply(vt[i], i);

        // Reset while a write strobe is active.
        @(posedge clk); #1;
        card_enable = 1'b1;
        bus.cpu_addr = 23'h500000;
        bus.cpu_rd = 1'b0;
        bus.cpu_hwr = 1'b1;
        bus.cpu_lwr = 1'b1;
        bus.cpu_data_in = 16'hC0DE;
        bus.cpu_sel = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid we_before", 32'(cc_we), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid dout", 32'(bus.cpu_data_out), 32'd0);
        bus.cpu_sel = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        apply(vt[0], 100);

        // Interrupt synchroniser, mask and set-over-clear priority.
        @(posedge clk); #1;
        cc_ireq = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("irq masked", 32'(irq), 32'd0);
        irq_enable = 1'b1;
        #1 chk("irq enabled", 32'(irq), 32'd1);
        irq_enable = 1'b0;
        #1 chk("irq remask", 32'(irq), 32'd0);
        irq_enable = 1'b1;
        #1 chk("irq pending_kept", 32'(irq), 32'd1);
        irq_clear = 1'b1;
        @(posedge clk); #1;
        irq_clear = 1'b0;
        chk("irq lone_clear1", 32'(irq), 32'd0);
        cc_ireq = 1'b0;
        repeat (4) @(posedge clk);
        #1 cc_ireq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        irq_clear = 1'b1;
        @(posedge clk); #1;
        irq_clear = 1'b0;
        chk("irq set_wins", 32'(irq), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("irq level_no_retrigger", 32'(irq), 32'd1);
        irq_clear = 1'b1;
        @(posedge clk); #1;
        irq_clear = 1'b0;
        chk("irq lone_clear2", 32'(irq), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("irq stays_clear", 32'(irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
